axis_seq_counter: RTL
=====================

# axis_seq_counter

Parametrised AXI-Stream counter engine. It accepts a length command on a slave stream and emits a counted sequence on a master stream through an internal FWFT buffer, with TLAST on the final beat. It stalls rather than drops on backpressure, and raises a sticky completion interrupt. It replaces the fixed 32-bit counter plus vendor FIFO pairing in the PL datapath between the DMA MM2S and S2MM channels.

## Interface
- DATA_W, 32: width of command and count data (≥2).
- FIFO_DEPTH, 16: buffer entries; power of two, ≥4.
- PROG_FULL, FIFO_DEPTH-2: fill level at which counting pauses and command intake stops; 2..FIFO_DEPTH.
- COUNT_DOWN, 0: 0 = emit 0..N-1; 1 = emit N-1..0.

Ports:
- axi_clk  in  1  single clock for all logic.
- axi_reset_n  in  1  asynchronous active-low reset.
- i_data_valid  in  1  slave command valid.
- i_data  in  DATA_W  command: sequence length N.
- o_data_ready  out  1  slave ready.
- o_data  out  DATA_W  master count value.
- o_data_valid  out  1  master valid.
- o_data_last  out  1  master TLAST, high on the final beat of each sequence.
- i_data_ready  in  1  master ready.
- o_intr  out  1  sticky completion interrupt.
- i_intr_clear  in  1  single-cycle clear of o_intr.
- o_busy  out  1  high when state is RUN or the buffer is non-empty.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.

## Operation
- FSM states: IDLE, RUN.
- Buffer: FIFO_DEPTH × (DATA_W+1) storing {last, value}. It is first-word fall-through: o_data_valid = (level != 0), and o_data/o_data_last come straight from the head entry.
- pf = (level >= PROG_FULL), computed from the registered level.
- o_data_ready = (state == IDLE) && !pf.
- IDLE:
  - Slave handshake with N == 0: the command is consumed, the FSM stays in IDLE, and there is no output and no interrupt.
  - Slave handshake with N ≠ 0: load rem = N and cnt = COUNT_DOWN ? N-1 : 0, then go to RUN.
- RUN:
  - Each cycle with !pf: push {rem == 1, cnt}, step cnt by ±1, and decrement rem.
  - When pushing with rem == 1, return to IDLE.
  - When pf is high: no push, and cnt/rem hold.
- Pop occurs on o_data_valid && i_data_ready.
- Push and pop in the same cycle leave the level unchanged. Pushes never occur at level ≥ PROG_FULL, so the buffer cannot overflow.
- Arithmetic is modulo 2^DATA_W. With N = 2^DATA_W-1, the up-count ends at 2^DATA_W-2 and never wraps.
- Back-to-back commands are accepted in IDLE while the previous sequence is still draining. Sequences stay contiguous, and each carries its own last flag.
- o_intr is set on a pop with last = 1 and cleared by i_intr_clear. If set and clear occur in the same cycle, set wins.
- The master interface follows AXI-Stream rules: once asserted, o_data_valid/o_data/o_data_last hold until handshake.

## Timing
- Reset values: o_data_valid 0, o_data_last 0, o_data 0, o_intr 0, o_busy 0, o_fifo_level 0, state IDLE, o_data_ready 1.
- Asserting reset mid-sequence empties the buffer, discards the sequence and clears o_intr, asynchronously. The first command is accepted on the first rising edge after deassertion.
- Command handshake at edge T → RUN at T+1 → first push at edge T+1 → o_data_valid high after T+1.
- With i_data_ready held high and PROG_FULL ≥ 2, throughput is 1 beat/cycle. A sequence of N beats occupies N cycles of RUN.
- The final beat pops at edge E; o_intr is high after E.
- o_busy falls the cycle after the final pop when the state is IDLE.
- o_fifo_level is registered and updates one edge after each push/pop.

## Test plan
- Basic: DATA_W=32, N=5, i_data_ready=1 → o_data 0,1,2,3,4 on consecutive cycles; last only on 4; o_intr rises after beat 4; i_intr_clear drops it next cycle.
- Down mode: COUNT_DOWN=1, N=3 → outputs 2,1,0; last on 0.
- Backpressure: N=40, FIFO_DEPTH=16, i_data_ready=0 for 50 cycles → level stops at 14, o_data_ready=0; after release, the values 0..39 arrive in order with no gaps or duplicates.
- Edge cases: N=0 → no output, no o_intr, o_data_ready stays 1. N=1 → a single beat 0 with last=1. Simultaneous intr set/clear → o_intr stays 1.
- Back-to-back: commands 3 then 2, sent while the first is draining → 0,1,2(last),0,1(last); o_intr set twice.
- Reset mid-run: assert axi_reset_n=0 after beat 6 of N=20 → all outputs reach reset values immediately. A new N=2 command afterwards yields exactly 0,1(last).

Source files
------------

// File: rtl/axis_seq_counter_if.sv
// Stream bundle for axis_seq_counter: length command in, counted beats out.
// Also carries interrupt, busy and buffer occupancy sideband.
interface axis_seq_counter_if #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              i_data_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_data_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              o_data_last;
  logic              i_data_ready;
  logic              o_intr;
  logic              i_intr_clear;
  logic              o_busy;
  logic [LW-1:0]     o_fifo_level;

  modport master (
    input  i_data_valid,
    input  i_data,
    output o_data_ready,
    output o_data,
    output o_data_valid,
    output o_data_last,
    input  i_data_ready,
    output o_intr,
    input  i_intr_clear,
    output o_busy,
    output o_fifo_level
  );

  modport slave (
    output i_data_valid,
    output i_data,
    input  o_data_ready,
    input  o_data,
    input  o_data_valid,
    input  o_data_last,
    output i_data_ready,
    input  o_intr,
    output i_intr_clear,
    input  o_busy,
    input  o_fifo_level
  );
endinterface

// File: rtl/axis_seq_counter.sv
// AXI-Stream sequence counter: length command in, 0..N-1 (or N-1..0) out
// through a fall-through buffer, TLAST on the final beat, sticky interrupt.
module axis_seq_counter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PROG_FULL  = FIFO_DEPTH - 2,
  parameter int COUNT_DOWN = 0
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  axis_seq_counter_if.master   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] PF_LVL = LW'(PROG_FULL);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              intr_q, intr_d;

  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W:0]   head;
  logic              pf;
  logic              vld;
  logic              push;
  logic              pop;
  logic              cmd_hs;

  always_comb begin
    head   = mem_q[rd_ptr_q];
    pf     = (level_q >= PF_LVL);
    vld    = (level_q != '0);
    pop    = vld && bus.i_data_ready;
    cmd_hs = (state_q == IDLE) && !pf && bus.i_data_valid;
    push   = (state_q == RUN) && !pf;

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;

    unique case (1'b1)
      (state_q == IDLE): begin
        // Zero-length commands are swallowed without leaving IDLE.
        if (cmd_hs && (bus.i_data != '0)) begin
          rem_d   = bus.i_data;
          cnt_d   = (COUNT_DOWN != 0) ? bus.i_data - ONE : '0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        if (push) begin
          cnt_d = (COUNT_DOWN != 0) ? cnt_q - ONE : cnt_q + ONE;
          rem_d = rem_q - ONE;
          if (rem_q == ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);

    // A final-beat pop overrides a same-cycle clear.
    intr_d = intr_q;
    if (bus.i_intr_clear) intr_d = 1'b0;
    if (pop && head[DATA_W]) intr_d = 1'b1;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      intr_q   <= intr_d;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem_q[wr_ptr_q] <= {(rem_q == ONE), cnt_q};
  end

  // Head is masked while empty so stale storage never shows after reset.
  assign bus.o_data       = vld ? head[DATA_W-1:0] : '0;
  assign bus.o_data_last  = vld & head[DATA_W];
  assign bus.o_data_valid = vld;
  assign bus.o_data_ready = (state_q == IDLE) && !pf;
  assign bus.o_intr       = intr_q;
  assign bus.o_busy       = (state_q == RUN) || vld;
  assign bus.o_fifo_level = level_q;

endmodule
